// File: rtl/spi_shift_frame.sv
// Parametrised SPI shift register: classic shift/rotate modes plus a FRAME mode
// that loads a word and shifts exactly `width` bits on external strobes.
module spi_shift_frame #(
   parameter int width    = 8,
   parameter bit msbFirst = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2:0]             mode,
   input  logic [width-1:0]       parallelIn,
   input  logic                   serialIn,
   input  logic                   shiftEn,
   output logic [width-1:0]       parallelOut,
   output logic                   serialOut,
   output logic                   busy,
   output logic                   frameDone,
   output logic [$clog2(width):0] count
);

   localparam int               cnt_w    = $clog2(width) + 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(width - 1);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'd0,
      MODE_PLOAD = 3'd1,
      MODE_RIGHT = 3'd2,
      MODE_LEFT  = 3'd3,
      MODE_ROTR  = 3'd4,
      MODE_ROTL  = 3'd5,
      MODE_FRAME = 3'd6,
      MODE_CLEAR = 3'd7
   } mode_e;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFTING
   } state_e;

   state_e           state_q, state_d;
   logic [width-1:0] data_q, data_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic [width-1:0] frame_shift;
   mode_e            mode_in;

   assign mode_in = mode_e'(mode);

   // Frame shifts reuse LEFT or RIGHT, chosen once at elaboration.
   assign frame_shift = msbFirst ? {data_q[width-2:0], serialIn}
                                 : {serialIn, data_q[width-1:1]};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      state_d      = state_q;
      data_d       = data_q;
      count_d      = count_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            case (mode_in)
               MODE_HOLD:  data_d = data_q;
               MODE_PLOAD: data_d = parallelIn;
               MODE_RIGHT: data_d = {serialIn, data_q[width-1:1]};
               MODE_LEFT:  data_d = {data_q[width-2:0], serialIn};
               MODE_ROTR:  data_d = {data_q[0], data_q[width-1:1]};
               MODE_ROTL:  data_d = {data_q[width-2:0], data_q[width-1]};
               MODE_FRAME: begin
                  // Load edge only: a strobe coinciding with FRAME is dropped.
                  data_d  = parallelIn;
                  count_d = '0;
                  busy_d  = 1'b1;
                  state_d = ST_SHIFTING;
               end
               MODE_CLEAR: begin
                  data_d  = '0;
                  count_d = '0;
               end
               default: data_d = data_q;
            endcase
         end

         ST_SHIFTING: begin
            if (mode_in == MODE_CLEAR) begin
               data_d  = '0;
               count_d = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (shiftEn) begin
               data_d  = frame_shift;
               count_d = count_q + cnt_w'(1);
               if (count_q == last_cnt) begin
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         data_q       <= '0;
         count_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         data_q       <= data_d;
         count_q      <= count_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign parallelOut = data_q;
   assign serialOut   = msbFirst ? data_q[width-1] : data_q[0];
   assign busy        = busy_q;
   assign frameDone   = frame_done_q;
   assign count       = count_q;

endmodule

// File: tb/tb_spi_shift_frame.sv
// Self-checking bench for spi_shift_frame: width 8 MSB-first and width 4 LSB-first
// instances, table-driven mode vectors plus scripted frame sequences.
module tb_spi_shift_frame;

   localparam logic [2:0] HOLD  = 3'd0;
   localparam logic [2:0] PLOAD = 3'd1;
   localparam logic [2:0] RIGHT = 3'd2;
   localparam logic [2:0] LEFT  = 3'd3;
   localparam logic [2:0] ROTR  = 3'd4;
   localparam logic [2:0] ROTL  = 3'd5;
   localparam logic [2:0] FRAME = 3'd6;
   localparam logic [2:0] CLEAR = 3'd7;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] m8, m4;
   logic [7:0] pin8, pout8;
   logic [3:0] pin4, pout4;
   logic       sin8, sen8, sout8, busy8, done8;
   logic       sin4, sen4, sout4, busy4, done4;
   logic [3:0] cnt8;
   logic [2:0] cnt4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic [3:0] cnt;
      logic       busy;
      logic       done;
      logic       sout;
   } exp_t;

   typedef struct {
      logic [2:0] mode;
      logic [7:0] pin;
      logic       sin;
      logic       sen;
      logic [7:0] q;
   } vec_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   spi_shift_frame #(.width(8), .msbFirst(1'b1)) dut8 (
      .clk(clk), .reset(rst), .mode(m8), .parallelIn(pin8), .serialIn(sin8),
      .shiftEn(sen8), .parallelOut(pout8), .serialOut(sout8), .busy(busy8),
      .frameDone(done8), .count(cnt8)
   );

   spi_shift_frame #(.width(4), .msbFirst(1'b0)) dut4 (
      .clk(clk), .reset(rst), .mode(m4), .parallelIn(pin4), .serialIn(sin4),
      .shiftEn(sen4), .parallelOut(pout4), .serialOut(sout4), .busy(busy4),
      .frameDone(done4), .count(cnt4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // MSB-first reference: start word shifted left k places, feed bits enter at bit 0.
   function automatic logic [7:0] frame8(input logic [7:0] start, input logic [7:0] feed, input int k);
      logic [15:0] a;
      logic [15:0] b;
      a = {8'h00, start} << k;
      b = {8'h00, feed} >> (8 - k);
      return 8'(a | b);
   endfunction

   // LSB-first reference with serialIn held at 1: ones enter from the top.
   function automatic logic [3:0] frame4(input logic [3:0] start, input int k);
      logic [7:0] a;
      a = {4'hF, start} >> k;
      return a[3:0];
   endfunction

   task automatic compare(input logic [7:0] q, input logic [3:0] cnt, input logic b,
                          input logic d, input logic so);
      exp_t got;
      got = sb.pop_front();
      check({got.tag, ".q"},    32'(q),   32'(got.q));
      check({got.tag, ".cnt"},  32'(cnt), 32'(got.cnt));
      check({got.tag, ".busy"}, 32'(b),   32'(got.busy));
      check({got.tag, ".done"}, 32'(d),   32'(got.done));
      check({got.tag, ".sout"}, 32'(so),  32'(got.sout));
   endtask

   task automatic step8(input logic [2:0] mode, input logic [7:0] pin, input logic s_in,
                        input logic s_en, input string tag, input logic [7:0] q,
                        input logic [3:0] cnt, input logic b, input logic d);
      exp_t e;
      m8 = mode; pin8 = pin; sin8 = s_in; sen8 = s_en;
      e.tag = tag; e.q = q; e.cnt = cnt; e.busy = b; e.done = d; e.sout = q[7];
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare(pout8, cnt8, busy8, done8, sout8);
   endtask

   task automatic step4(input logic [2:0] mode, input logic [3:0] pin, input logic s_in,
                        input logic s_en, input string tag, input logic [3:0] q,
                        input logic [2:0] cnt, input logic b, input logic d);
      exp_t e;
      m4 = mode; pin4 = pin; sin4 = s_in; sen4 = s_en;
      e.tag = tag; e.q = {4'h0, q}; e.cnt = {1'b0, cnt}; e.busy = b; e.done = d; e.sout = q[0];
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare({4'h0, pout4}, {1'b0, cnt4}, busy4, done4, sout4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vt[12];
      logic [7:0] feed;
      logic [7:0] sout_seq;
      logic [3:0] sout_seq4;

      vt[0]  = '{PLOAD, 8'hA5, 1'b0, 1'b0, 8'hA5};
      vt[1]  = '{RIGHT, 8'h00, 1'b1, 1'b0, 8'hD2};
      vt[2]  = '{LEFT,  8'h00, 1'b0, 1'b0, 8'hA4};
      vt[3]  = '{HOLD,  8'h00, 1'b1, 1'b0, 8'hA4};
      vt[4]  = '{ROTR,  8'h00, 1'b1, 1'b0, 8'h52};
      vt[5]  = '{ROTL,  8'h00, 1'b0, 1'b0, 8'hA4};
      vt[6]  = '{CLEAR, 8'hFF, 1'b1, 1'b1, 8'h00};
      vt[7]  = '{PLOAD, 8'h81, 1'b0, 1'b1, 8'h81};
      vt[8]  = '{ROTL,  8'h00, 1'b0, 1'b1, 8'h03};
      vt[9]  = '{ROTR,  8'h00, 1'b0, 1'b0, 8'h81};
      vt[10] = '{RIGHT, 8'h00, 1'b0, 1'b0, 8'h40};
      vt[11] = '{LEFT,  8'h00, 1'b1, 1'b0, 8'h81};

      rst = 1'b1;
      m8 = HOLD; pin8 = '0; sin8 = 1'b0; sen8 = 1'b0;
      m4 = HOLD; pin4 = '0; sin4 = 1'b0; sen4 = 1'b0;
      #12;
      rst = 1'b0;
      #1;
      check("reset.q8",    32'(pout8), 32'h0);
      check("reset.cnt8",  32'(cnt8),  32'h0);
      check("reset.busy8", 32'(busy8), 32'h0);
      check("reset.done8", 32'(done8), 32'h0);
      check("reset.q4",    32'(pout4), 32'h0);

      // Idle modes from the table; count/busy/done must stay at zero throughout.
      for (int i = 0; i < 12; i++)
         step8(vt[i].mode, vt[i].pin, vt[i].sin, vt[i].sen, $sformatf("vec%0d", i),
               vt[i].q, 4'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-frame, away from any clock edge.
      step8(FRAME, 8'hA5, 1'b0, 1'b0, "rst_ld", 8'hA5, 4'd0, 1'b1, 1'b0);
      step8(HOLD,  8'h00, 1'b1, 1'b1, "rst_sh", 8'h4B, 4'd1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid.q",    32'(pout8), 32'h0);
      check("rst_mid.cnt",  32'(cnt8),  32'h0);
      check("rst_mid.busy", 32'(busy8), 32'h0);
      check("rst_mid.done", 32'(done8), 32'h0);
      rst = 1'b0;
      step8(HOLD, 8'h00, 1'b1, 1'b1, "post_rst", 8'h00, 4'd0, 1'b0, 1'b0);

      // Full MSB-first frame, strobe every other cycle.
      feed     = 8'h3C;
      sout_seq = 8'h96;
      step8(FRAME, 8'h96, 1'b0, 1'b0, "fa_ld", 8'h96, 4'd0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         step8(HOLD, 8'h00, 1'b0, 1'b0, $sformatf("fa_gap%0d", k),
               frame8(8'h96, feed, k), 4'(k), 1'b1, 1'b0);
         check($sformatf("fa_serial%0d", k), 32'(sout8), 32'(sout_seq[7-k]));
         step8(HOLD, 8'h00, feed[7-k], 1'b1, $sformatf("fa_sh%0d", k),
               frame8(8'h96, feed, k + 1), 4'(k + 1), (k < 7), (k == 7));
      end
      step8(HOLD, 8'h00, 1'b0, 1'b0, "fa_after", 8'h3C, 4'd8, 1'b0, 1'b0);
      step8(LEFT, 8'h00, 1'b1, 1'b0, "fa_idle_left", 8'h79, 4'd8, 1'b0, 1'b0);

      // Interrupted frame: PLOAD ignored, CLEAR aborts without frameDone.
      step8(FRAME, 8'h96, 1'b0, 1'b0, "fb_ld", 8'h96, 4'd0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++)
         step8(HOLD, 8'h00, feed[7-k], 1'b1, $sformatf("fb_sh%0d", k),
               frame8(8'h96, feed, k + 1), 4'(k + 1), 1'b1, 1'b0);
      step8(PLOAD, 8'hFF, 1'b0, 1'b0, "fb_pload", frame8(8'h96, feed, 3), 4'd3, 1'b1, 1'b0);
      step8(CLEAR, 8'h00, 1'b1, 1'b1, "fb_clear", 8'h00, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step8(HOLD, 8'h00, 1'b1, 1'b1, $sformatf("fb_nodone%0d", i), 8'h00, 4'd0, 1'b0, 1'b0);
      step8(RIGHT, 8'h00, 1'b1, 1'b0, "fb_idle", 8'h80, 4'd0, 1'b0, 1'b0);

      // Strobe corner cases: strobe on load edge, long stall, back-to-back frames.
      step8(FRAME, 8'h5A, 1'b1, 1'b1, "ec_ld", 8'h5A, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++)
         step8(3'(i % 7), 8'hFF, 1'b1, 1'b0, $sformatf("ec_stall%0d", i),
               8'h5A, 4'd0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++)
         step8(HOLD, 8'h00, 1'b0, 1'b1, $sformatf("ec_sh%0d", k),
               frame8(8'h5A, 8'h00, k + 1), 4'(k + 1), (k < 7), (k == 7));
      step8(FRAME, 8'hC3, 1'b0, 1'b0, "ec_b2b", 8'hC3, 4'd0, 1'b1, 1'b0);
      step8(HOLD,  8'h00, 1'b1, 1'b1, "ec_b2b_sh", 8'h87, 4'd1, 1'b1, 1'b0);
      step8(CLEAR, 8'h00, 1'b0, 1'b0, "ec_end", 8'h00, 4'd0, 1'b0, 1'b0);

      // Width 4, LSB first, serialIn held high.
      m8 = HOLD; sen8 = 1'b0;
      sout_seq4 = 4'b1010;
      step4(FRAME, 4'b1010, 1'b1, 1'b0, "w4_ld", 4'b1010, 3'd0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("w4_serial%0d", k), 32'(sout4), 32'(sout_seq4[k]));
         step4(HOLD, 4'b0000, 1'b1, 1'b1, $sformatf("w4_sh%0d", k),
               frame4(4'b1010, k + 1), 3'(k + 1), (k < 3), (k == 3));
      end
      check("w4_final", 32'(pout4), 32'hF);

      // Reset landing in the frameDone cycle clears the pulse immediately.
      #2;
      rst = 1'b1;
      #1;
      check("rst_done.done", 32'(done4), 32'h0);
      check("rst_done.cnt",  32'(cnt4),  32'h0);
      check("rst_done.q",    32'(pout4), 32'h0);
      check("rst_done.busy", 32'(busy4), 32'h0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
